// File: rtl/stream_demux_if.sv
// stream_demux_if: input stream, per-channel outputs and status of stream_demux; bcast exists only with STREAM_DEMUX_BCAST_EN
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int NCH = 4
);
  localparam int SEL_W = (NCH > 2) ? $clog2(NCH) : 1;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic in_valid;
  logic in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0] out_valid;
  logic [NCH-1:0] out_ready;
  logic err;
  logic [7:0] drop_cnt;
`ifdef STREAM_DEMUX_BCAST_EN
  logic bcast;
  modport master (output in_data, in_sel, in_valid, out_ready, bcast,
                  input in_ready, out_data, out_valid, err, drop_cnt);
  modport slave (input in_data, in_sel, in_valid, out_ready, bcast,
                 output in_ready, out_data, out_valid, err, drop_cnt);
`else
  modport master (output in_data, in_sel, in_valid, out_ready,
                  input in_ready, out_data, out_valid, err, drop_cnt);
  modport slave (input in_data, in_sel, in_valid, out_ready,
                 output in_ready, out_data, out_valid, err, drop_cnt);
`endif
endinterface

// File: rtl/stream_demux.sv
// stream_demux: 1-to-NCH stream demux with a one-entry register per channel; STREAM_DEMUX_BCAST_EN adds broadcast
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int NCH = 4
) (
  input logic clk,
  input logic rst_n,
  stream_demux_if.slave s
);
  localparam int SEL_W = (NCH > 2) ? $clog2(NCH) : 1;
  localparam logic [SEL_W:0] NCH_V = (SEL_W + 1)'(NCH);
  logic [NCH-1:0][WIDTH-1:0] data_q;
  logic [NCH-1:0] valid_q, drain, free, load;
  logic [7:0] cnt_q;
  logic err_q, legal, bc, sel_free, rdy, fire, drop;
`ifdef STREAM_DEMUX_BCAST_EN
  assign bc = s.bcast;
`else
  assign bc = 1'b0;
`endif
  assign legal = {1'b0, s.in_sel} < NCH_V;
  always_comb begin
    drain = valid_q & s.out_ready;
    free = ~valid_q | s.out_ready;
    sel_free = 1'b0;
    for (int k = 0; k < NCH; k++) sel_free = sel_free | (free[k] & (k == int'(s.in_sel)));
    rdy = rst_n & (bc ? &free : (!legal | sel_free));
    fire = s.in_valid & rdy;
    drop = fire & !bc & !legal;
    load = '0;
    for (int k = 0; k < NCH; k++) load[k] = fire & (bc | (legal & (k == int'(s.in_sel))));
  end
  // a drained channel reads back as zero so stale words never linger on the bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      valid_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          data_q[k] <= s.in_data;
          valid_q[k] <= 1'b1;
        end else if (drain[k]) begin
          data_q[k] <= '0;
          valid_q[k] <= 1'b0;
        end
      end
      err_q <= drop;
      if (drop && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end
  assign s.in_ready = rdy;
  assign s.out_data = data_q;
  assign s.out_valid = valid_q;
  assign s.err = err_q;
  assign s.drop_cnt = cnt_q;
endmodule
